// File: rtl/cd_tx_pkg.sv
// Shared definitions for the TX retry scheduler: one-hot state encoding and backoff LFSR constants.
package cd_tx_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'b001,
        StArm     = 3'b010,
        StBackoff = 3'b100
    } tx_state_e;

    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS     = 16'h002D;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {^(v & LFSR_TAPS), v[15:1]};
    endfunction

endpackage

// File: rtl/tx_backoff_gen.sv
// Free-running backoff LFSR and the bit-time backoff down-counter it seeds.
module tx_backoff_gen
    import cd_tx_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_load,
    input  logic [7:0] i_base,
    input  logic [7:0] i_mask,
    input  logic       i_bit_tick,
    output logic       o_zero
);

    logic [15:0] r_lfsr;
    logic [8:0]  r_bo_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lfsr   <= LFSR_SEED;
            r_bo_cnt <= '0;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
            if (i_load) begin
                // 9-bit sum so base + random part never wraps.
                r_bo_cnt <= {1'b0, i_base} + {1'b0, r_lfsr[7:0] & i_mask};
            end else if (i_bit_tick && (r_bo_cnt != 9'd0)) begin
                r_bo_cnt <= r_bo_cnt - 9'd1;
            end
        end
    end

    assign o_zero = (r_bo_cnt == 9'd0);

endmodule

// File: rtl/tx_retry_sched.sv
// Ping-pong TX page scheduler: presents pending pages to the serializer, backs off on collision.
module tx_retry_sched
    import cd_tx_pkg::*;
#(
    parameter int unsigned RETRY_W   = 4,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_tx_switch,
    input  logic               i_tx_abort,
    input  logic [RETRY_W-1:0] i_max_retry,
    input  logic [7:0]         i_backoff_base,
    input  logic [7:0]         i_backoff_mask,
    input  logic               i_bit_tick,
    input  logic               i_ser_cd,
    input  logic               i_ser_err,
    input  logic               i_ser_read_done,
    output logic               o_ser_unread,
    output logic               o_ser_abort,
    output logic               o_ser_page,
    output logic               o_wr_page,
    output logic               o_buf_free,
    output logic [RETRY_W-1:0] o_retry_cnt,
    output logic               o_done_pulse,
    output logic               o_err_pulse,
    output logic               o_cd_pulse,
    output logic               o_drop_pulse,
    output logic               o_ovf_pulse
);

    tx_state_e          r_state, w_state_d;
    logic [1:0]         r_pend, w_pend_d;
    logic               r_wr_page, w_wr_page_d;
    logic               r_rd_page, w_rd_page_d;
    logic [RETRY_W-1:0] r_retry_cnt, w_retry_cnt_d;
    logic [RETRY_W:0]   w_retry_inc;
    logic               r_err_seen, w_err_seen_d;
    logic               r_ser_unread, w_ser_unread_d;
    logic               r_ser_abort, w_ser_abort_d;
    logic               r_done, w_done_d;
    logic               r_err, w_err_d;
    logic               r_cd, w_cd_d;
    logic               r_drop, w_drop_d;
    logic               r_ovf, w_ovf_d;
    logic               w_buf_free;
    logic               w_release;
    logic               w_bo_load;
    logic               w_bo_zero;

    tx_backoff_gen #(
        .LFSR_SEED (LFSR_SEED)
    ) u_backoff (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (w_bo_load),
        .i_base     (i_backoff_base),
        .i_mask     (i_backoff_mask),
        .i_bit_tick (i_bit_tick),
        .o_zero     (w_bo_zero)
    );

    assign w_buf_free  = !r_pend[r_wr_page];
    assign w_retry_inc = {1'b0, r_retry_cnt} + {{RETRY_W{1'b0}}, 1'b1};

    always_comb begin
        w_state_d     = r_state;
        w_pend_d      = r_pend;
        w_wr_page_d   = r_wr_page;
        w_rd_page_d   = r_rd_page;
        w_retry_cnt_d = r_retry_cnt;
        w_err_seen_d  = r_err_seen;
        w_ser_abort_d = 1'b0;
        w_done_d      = 1'b0;
        w_err_d       = 1'b0;
        w_cd_d        = 1'b0;
        w_drop_d      = 1'b0;
        w_ovf_d       = 1'b0;
        w_release     = 1'b0;
        w_bo_load     = 1'b0;

        if (i_tx_abort) begin
            w_ser_abort_d = 1'b1;
            w_pend_d      = 2'b00;
            w_rd_page_d   = r_wr_page;
            w_retry_cnt_d = '0;
            w_err_seen_d  = 1'b0;
            w_state_d     = StIdle;
        end else begin
            if (i_tx_switch) begin
                if (w_buf_free) begin
                    w_pend_d[r_wr_page] = 1'b1;
                    w_wr_page_d         = !r_wr_page;
                end else begin
                    w_ovf_d = 1'b1;
                end
            end

            unique case (r_state)
                StIdle: begin
                    if (r_pend[r_rd_page]) w_state_d = StArm;
                end
                StArm: begin
                    if (i_ser_err) w_err_seen_d = 1'b1;
                    if (i_ser_cd) begin
                        w_cd_d = 1'b1;
                        if ((i_max_retry != '0) && (w_retry_inc >= {1'b0, i_max_retry})) begin
                            w_drop_d  = 1'b1;
                            w_release = 1'b1;
                        end else begin
                            w_retry_cnt_d = w_retry_inc[RETRY_W-1:0];
                            w_bo_load     = 1'b1;
                            w_state_d     = StBackoff;
                        end
                    end else if (i_ser_read_done) begin
                        w_release = 1'b1;
                        if (r_err_seen || i_ser_err) w_err_d  = 1'b1;
                        else                         w_done_d = 1'b1;
                    end
                end
                StBackoff: begin
                    if (w_bo_zero) w_state_d = StArm;
                end
                default: w_state_d = StIdle;
            endcase

            // Release only touches the read page; a same-cycle commit only touches the write page.
            if (w_release) begin
                w_pend_d[r_rd_page] = 1'b0;
                w_rd_page_d         = !r_rd_page;
                w_retry_cnt_d       = '0;
                w_err_seen_d        = 1'b0;
                w_state_d           = StIdle;
            end
        end

        w_ser_unread_d = (w_state_d == StArm) && w_pend_d[w_rd_page_d];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StIdle;
            r_pend       <= 2'b00;
            r_wr_page    <= 1'b0;
            r_rd_page    <= 1'b0;
            r_retry_cnt  <= '0;
            r_err_seen   <= 1'b0;
            r_ser_unread <= 1'b0;
            r_ser_abort  <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_cd         <= 1'b0;
            r_drop       <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_pend       <= w_pend_d;
            r_wr_page    <= w_wr_page_d;
            r_rd_page    <= w_rd_page_d;
            r_retry_cnt  <= w_retry_cnt_d;
            r_err_seen   <= w_err_seen_d;
            r_ser_unread <= w_ser_unread_d;
            r_ser_abort  <= w_ser_abort_d;
            r_done       <= w_done_d;
            r_err        <= w_err_d;
            r_cd         <= w_cd_d;
            r_drop       <= w_drop_d;
            r_ovf        <= w_ovf_d;
        end
    end

    assign o_ser_unread = r_ser_unread;
    assign o_ser_abort  = r_ser_abort;
    assign o_ser_page   = r_rd_page;
    assign o_wr_page    = r_wr_page;
    assign o_buf_free   = w_buf_free;
    assign o_retry_cnt  = r_retry_cnt;
    assign o_done_pulse = r_done;
    assign o_err_pulse  = r_err;
    assign o_cd_pulse   = r_cd;
    assign o_drop_pulse = r_drop;
    assign o_ovf_pulse  = r_ovf;

endmodule

// File: tb/tb_tx_retry_sched.sv
// Directed plus randomized bench for tx_retry_sched against a behavioural page/retry model.
module tb_tx_retry_sched;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          tx_switch = 1'b0;
    logic          tx_abort = 1'b0;
    logic [RW-1:0] max_retry = '0;
    logic [7:0]    backoff_base = 8'd0;
    logic [7:0]    backoff_mask = 8'd0;
    logic          bit_tick = 1'b0;
    logic          ser_cd = 1'b0;
    logic          ser_err = 1'b0;
    logic          ser_read_done = 1'b0;
    logic          ser_unread, ser_abort, ser_page, wr_page, buf_free;
    logic [RW-1:0] retry_cnt;
    logic          done_pulse, err_pulse, cd_pulse, drop_pulse, ovf_pulse;

    always #5 clk = ~clk;

    tx_retry_sched #(
        .RETRY_W   (RW),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (reset_n),
        .i_tx_switch     (tx_switch),
        .i_tx_abort      (tx_abort),
        .i_max_retry     (max_retry),
        .i_backoff_base  (backoff_base),
        .i_backoff_mask  (backoff_mask),
        .i_bit_tick      (bit_tick),
        .i_ser_cd        (ser_cd),
        .i_ser_err       (ser_err),
        .i_ser_read_done (ser_read_done),
        .o_ser_unread    (ser_unread),
        .o_ser_abort     (ser_abort),
        .o_ser_page      (ser_page),
        .o_wr_page       (wr_page),
        .o_buf_free      (buf_free),
        .o_retry_cnt     (retry_cnt),
        .o_done_pulse    (done_pulse),
        .o_err_pulse     (err_pulse),
        .o_cd_pulse      (cd_pulse),
        .o_drop_pulse    (drop_pulse),
        .o_ovf_pulse     (ovf_pulse)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: which pages hold frames, which page is on offer, and how long the backoff lasts.
    bit [1:0]  m_pend = 2'b00;
    bit        m_wr = 1'b0, m_rd = 1'b0;
    bit        m_offered = 1'b0;
    bit        m_waiting = 1'b0;
    bit        m_err_seen = 1'b0;
    int        m_wait_bits = 0;
    int        m_retries = 0;
    bit [15:0] m_lfsr = 16'hACE1;
    bit [5:0]  m_pulses = 6'd0; // {abort, done, err, cd, drop, ovf}

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("ser_unread", 32'(ser_unread), 32'(m_offered && m_pend[m_rd]));
        check_eq("pages", 32'({ser_page, wr_page, buf_free}), 32'({m_rd, m_wr, !m_pend[m_wr]}));
        check_eq("retry_cnt", 32'(retry_cnt), 32'(m_retries));
        check_eq("pulses", 32'({ser_abort, done_pulse, err_pulse, cd_pulse, drop_pulse, ovf_pulse}),
                 32'(m_pulses));
    endtask

    task automatic model_step(input bit sw, input bit ab, input bit tk, input bit cd,
                              input bit er, input bit rd);
        bit [15:0] l = m_lfsr;
        bit [1:0]  pend0 = m_pend;
        bit        rd0 = m_rd;
        bit        release_pg = 1'b0;
        int        next_retry;
        m_lfsr   = (l >> 1) | (16'(l[0] ^ l[2] ^ l[3] ^ l[5]) << 15);
        m_pulses = 6'd0;
        if (ab) begin
            m_pulses[5] = 1'b1;
            m_pend      = 2'b00;
            m_rd        = m_wr;
            m_retries   = 0;
            m_err_seen  = 1'b0;
            m_offered   = 1'b0;
            m_waiting   = 1'b0;
            return;
        end
        if (sw) begin
            if (!pend0[m_wr]) begin
                m_pend[m_wr] = 1'b1;
                m_wr         = !m_wr;
            end else begin
                m_pulses[0] = 1'b1;
            end
        end
        if (m_offered) begin
            if (er) m_err_seen = 1'b1;
            if (cd) begin
                m_pulses[2] = 1'b1;
                next_retry  = m_retries + 1;
                if (max_retry != 0 && next_retry >= int'(max_retry)) begin
                    m_pulses[1] = 1'b1;
                    release_pg  = 1'b1;
                end else begin
                    m_retries   = next_retry % (1 << RW);
                    m_wait_bits = int'(backoff_base) + int'(l[7:0] & backoff_mask);
                    m_offered   = 1'b0;
                    m_waiting   = 1'b1;
                end
            end else if (rd) begin
                release_pg = 1'b1;
                if (m_err_seen) m_pulses[3] = 1'b1;
                else            m_pulses[4] = 1'b1;
            end
        end else if (m_waiting) begin
            if (m_wait_bits == 0) begin
                m_waiting = 1'b0;
                m_offered = 1'b1;
            end else if (tk) begin
                m_wait_bits--;
            end
        end else if (pend0[rd0]) begin
            m_offered = 1'b1;
        end
        if (release_pg) begin
            m_pend[rd0] = 1'b0;
            m_rd        = !rd0;
            m_retries   = 0;
            m_err_seen  = 1'b0;
            m_offered   = 1'b0;
        end
    endtask

    task automatic step(input bit sw, input bit ab, input bit tk, input bit cd,
                        input bit er, input bit rd);
        tx_switch     = sw;
        tx_abort      = ab;
        bit_tick      = tk;
        ser_cd        = cd;
        ser_err       = er;
        ser_read_done = rd;
        model_step(sw, ab, tk, cd, er, rd);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_outputs();

        // Single frame, then ping-pong with overflow.
        step(1, 0, 0, 0, 0, 0); idle(3);
        step(0, 0, 0, 0, 0, 1); idle(2);
        step(1, 0, 0, 0, 0, 0); idle(4);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(2); step(0, 0, 0, 0, 0, 1); idle(3);
        step(0, 0, 0, 0, 0, 1); idle(2);

        // Collision with fixed backoff of 4 bit times.
        backoff_base = 8'd4;
        step(1, 0, 0, 0, 0, 0); idle(3);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, i[0], 0, 0, 0);
        step(0, 0, 0, 0, 0, 1); idle(2);

        // Retry exhaustion at 3, then unlimited retries.
        max_retry = 4'd3;
        step(1, 0, 0, 0, 0, 0); idle(3);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 0, 0);
            repeat (7) step(0, 0, 1, 0, 0, 0);
        end
        max_retry = 4'd0;
        step(1, 0, 0, 0, 0, 0); idle(3);
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0, 1, 0, 0);
            repeat (7) step(0, 0, 1, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0, 1); idle(2);

        // Error then read_done; abort mid-backoff with a stale read_done echo.
        step(1, 0, 0, 0, 0, 0); idle(3);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1); idle(2);
        step(1, 0, 0, 0, 0, 0); idle(3);
        step(0, 0, 0, 1, 0, 0); idle(1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1); idle(2);

        for (int ph = 0; ph < 4; ph++) begin
            max_retry    = RW'($urandom_range(0, 4));
            backoff_base = 8'($urandom_range(0, 6));
            backoff_mask = 8'((1 << $urandom_range(0, 4)) - 1);
            for (int c = 0; c < 1500; c++) begin
                int unsigned r = $urandom_range(0, 15);
                step($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
                     $urandom_range(0, 2) == 0, r == 0, $urandom_range(0, 19) == 0,
                     (r == 1) || (r == 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tx_retry_sched.md
Name: tx_retry_sched

Overview:
Transmit-side controller that sequences the byte serializer over a two-page (ping-pong) TX frame buffer. It tracks which pages hold pending frames and presents one page at a time to the serializer. On collision it retries after a pseudo-random backoff measured in bus bit times, and drops frames on error or when retries run out. It sits between the host/register block and the serializer, and drives the serializer's unread/abort inputs and the page-select MSB of the buffer address.

Parameters:
RETRY_W, 4, width of max_retry and retry_cnt
LFSR_SEED, 16'hACE1, reset value of backoff LFSR (must be non-zero)

Ports:
clk  in  1  clock
reset_n  in  1  async reset, active low
tx_switch  in  1  host pulse: page being written is complete, commit it
tx_abort  in  1  host pulse: cancel everything
max_retry  in  RETRY_W  collision retries before drop; 0 = unlimited
backoff_base  in  8  fixed backoff, bit times
backoff_mask  in  8  mask applied to LFSR[7:0] for random part
bit_tick  in  1  one-cycle pulse per bus bit (from rx deserializer)
ser_cd  in  1  serializer collision pulse
ser_err  in  1  serializer tx/rx mismatch pulse
ser_read_done  in  1  serializer frame-finished pulse
ser_unread  out  1  frame available to serializer
ser_abort  out  1  abort to serializer
ser_page  out  1  page serializer reads (buffer addr MSB)
wr_page  out  1  page host writes
buf_free  out  1  host may write wr_page
retry_cnt  out  RETRY_W  collisions on current frame
done_pulse / err_pulse / cd_pulse / drop_pulse / ovf_pulse  out  1 each  status pulses

Behaviour:
- Reset: all outputs 0 except buf_free=1; pend=2'b00; ser_page=0; wr_page=0; state IDLE; LFSR=LFSR_SEED.
- pend[1:0]: per-page valid bits. buf_free = !pend[wr_page]; ser_page = rd_page.
- tx_switch with buf_free: set pend[wr_page] and toggle wr_page next cycle. tx_switch without buf_free: ignored; ovf_pulse 1 cycle.
- States: IDLE, ARM, BACKOFF. ser_unread = (state==ARM) && pend[rd_page], registered.
- IDLE -> ARM when pend[rd_page]=1.
- ARM, ser_cd: cd_pulse; retry_cnt+1.
  - If max_retry!=0 and retry_cnt+1 >= max_retry: drop_pulse; clear pend[rd_page]; toggle rd_page; retry_cnt=0; -> IDLE.
  - Else: load bo_cnt = backoff_base + (LFSR[7:0] & backoff_mask), 9-bit sum, no saturation; -> BACKOFF.
  - ser_unread is low from the next cycle.
- BACKOFF: bo_cnt decrements on bit_tick. When bo_cnt==0: -> ARM. A zero load spends exactly 1 cycle in BACKOFF.
- ARM, ser_err: latch err_seen. A ser_err arriving in the same cycle as ser_read_done is also seen.
- ARM, ser_read_done: clear pend[rd_page]; toggle rd_page; retry_cnt=0; err_seen=0; -> IDLE (re-arms the next cycle if the other page is pending). Pulse err_pulse if err_seen, else done_pulse.
- ser_read_done and ser_cd outside ARM: ignored (covers the read_done echo after abort).
- tx_switch and a page release in the same cycle: both applied (they act on different pages).
- tx_abort, highest priority: ser_abort=1 for 1 cycle; pend=0; rd_page=wr_page; retry_cnt=0; err_seen=0; -> IDLE. No status pulse. Any tx_switch in the same cycle is discarded.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clock regardless of state.
- All status pulses are exactly 1 cycle and registered.

Decomposition:
- Package cd_tx_pkg: state encoding (one-hot IDLE/ARM/BACKOFF), LFSR tap mask, LFSR_SEED default.
- Sub-module tx_backoff_gen: LFSR plus bo_cnt load/decrement, with load, bit_tick inputs and a zero output.

Test Plan:
- Single frame: tx_switch at t0 -> pend=01, wr_page=1, ser_unread=1 by t2; ser_read_done -> done_pulse, ser_unread=0, pend=00, ser_page=1.
- Ping-pong: two tx_switch 5 cycles apart -> second accepted, buf_free=0; third tx_switch -> ovf_pulse. After first read_done, ser_page toggles and ser_unread re-asserts within 2 cycles.
- Collision backoff: base=4, mask=0, ser_cd -> cd_pulse, retry_cnt=1, ser_unread low for exactly 4 bit_ticks, then high.
- Retry exhaust: max_retry=3, three ser_cd -> third gives drop_pulse, pend bit cleared, retry_cnt=0. With max_retry=0, 20 collisions produce no drop.
- Error: ser_err, then ser_read_done the next cycle -> err_pulse, no done_pulse, page released.
- Abort mid-backoff: tx_abort -> ser_abort 1 cycle, pend=00, buf_free=1, state IDLE; a ser_read_done 1 cycle later produces no pulse.
